// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a 1-cycle-latency data memory.
// Define DMEM_ARB_RR_EN for round-robin; default is fixed priority with a starvation guard.
module dmem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_LIM = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          m0_req,
  input  logic [3:0]    m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic gnt0;
  logic gnt1;
  logic own_q;
  logic own_d;
  logic rd_q;
  logic rd_d;

`ifdef DMEM_ARB_RR_EN
  logic last_q;
  logic last_d;

  // Round-robin pick: on contention the port not granted last wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (sys_rst_n) begin
      gnt1 = m1_req & (~m0_req | ~last_q);
      gnt0 = m0_req & ~gnt1;
    end
    last_d = last_q;
    if (gnt1)
      last_d = 1'b1;
    else if (gnt0)
      last_d = 1'b0;
  end

  // Pointer resets to "m1 granted last" so m0 wins first contention
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      last_q <= 1'b1;
    else
      last_q <= last_d;
  end
`else
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          starved;

  // Fixed m0 priority, m1 forced through once it has waited LIM cycles
  always_comb begin
    starved = (wait_q == LIM);
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (sys_rst_n) begin
      gnt1 = m1_req & (~m0_req | starved);
      gnt0 = m0_req & ~gnt1;
    end
    wait_d = '0;
    if (m1_req && !gnt1)
      wait_d = starved ? wait_q : wait_q + CW'(1);
  end

  // Saturating m1 wait counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      wait_q <= '0;
    else
      wait_q <= wait_d;
  end
`endif

  // Steer the granted requester onto the memory port; tag reads by owner
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
    own_d = gnt1;
    rd_d  = (gnt1 && m1_we == 4'b0000)
          | (gnt0 && m0_we == 4'b0000);
  end

  // Owner tag and read flag follow the access into the data cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      own_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      own_q <= own_d;
      rd_q  <= rd_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_q & ~own_q;
  assign m1_rvalid = rd_q & own_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
